// File: rtl/shifter_operand_fetch_pkg.sv
// Shared definitions for the shifter operand fetch stage and the barrel shifter.
// Latency: n/a (constants, types and field positions only).
// Backpressure: n/a.
//
// Contents:
//   - shift type codes and the shifter op encoding {shift_type, reg_shift}
//   - fetch FSM state codes
//   - bit positions of the data-processing shifter_operand fields
//   - default PC read-ahead offsets
package shifter_operand_fetch_pkg;

  // Shift types as they appear in instr[6:5].
  localparam logic [1:0] SHT_LSL = 2'b00;
  localparam logic [1:0] SHT_LSR = 2'b01;
  localparam logic [1:0] SHT_ASR = 2'b10;
  localparam logic [1:0] SHT_ROR = 2'b11;

  // Shifter op = {shift_type, reg_shift}.
  localparam logic [2:0] SHOP_PASS    = {SHT_LSL, 1'b0};  // LSL #0: value and carry pass through
  localparam logic [2:0] SHOP_ROR_IMM = {SHT_ROR, 1'b0};  // rotated 8-bit immediate

  // Fetch FSM states.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RD_RM = 2'd1;
  localparam logic [1:0] ST_RD_RS = 2'd2;
  localparam logic [1:0] ST_OUT   = 2'd3;

  // Instruction field positions.
  localparam int F_I        = 25;
  localparam int F_ROT_HI   = 11;
  localparam int F_ROT_LO   = 8;
  localparam int F_IMM8_HI  = 7;
  localparam int F_IMM8_LO  = 0;
  localparam int F_SHAMT_HI = 11;
  localparam int F_SHAMT_LO = 7;
  localparam int F_TYPE_HI  = 6;
  localparam int F_TYPE_LO  = 5;
  localparam int F_RSH      = 4;
  localparam int F_RS_HI    = 11;
  localparam int F_RS_LO    = 8;
  localparam int F_RM_HI    = 3;
  localparam int F_RM_LO    = 0;

  // Register number of the PC.
  localparam logic [3:0] REG_PC = 4'd15;

  // Default PC read-ahead: the PC reads as this much beyond the instruction address.
  localparam logic [31:0] DEF_PC_AHEAD_IMM = 32'd8;
  localparam logic [31:0] DEF_PC_AHEAD_REG = 32'd12;

  // Zero-extend the 8-bit immediate of an I=1 instruction.
  function automatic logic [31:0] imm8_zext(input logic [31:0] instr);
    return {24'b0, instr[F_IMM8_HI:F_IMM8_LO]};
  endfunction

endpackage

// File: rtl/shifter_operand_fetch.sv
// Decodes a data-processing shifter_operand, reads Rm/Rs over one shared RF port, registers shifter operands.
// Latency: 1 cycle immediate form, 2 cycles immediate shift, 3 cycles register shift (accept to out_valid).
// Backpressure: holds all sh_* stable in OUT until out_ready; in_ready drops while busy or on flush.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   flush               synchronous kill of the in-flight operation
//   in_valid/in_ready   instruction handshake; in_instr, in_pc, in_cflag sampled on acceptance
//   rf_addr/rf_rdata    shared register file read port (combinational read data)
//   out_valid/out_ready operand handshake to the barrel shifter
//   sh_op, sh_in, sh_cin, sh_imm, sh_reg   registered shifter operands
module shifter_operand_fetch
  import shifter_operand_fetch_pkg::*;
#(
  parameter logic [31:0] PC_AHEAD_IMM = DEF_PC_AHEAD_IMM,
  parameter logic [31:0] PC_AHEAD_REG = DEF_PC_AHEAD_REG
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_pc,
  input  logic        in_cflag,
  output logic [3:0]  rf_addr,
  input  logic [31:0] rf_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [2:0]  sh_op,
  output logic [31:0] sh_in,
  output logic        sh_cin,
  output logic [4:0]  sh_imm,
  output logic [7:0]  sh_reg
);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [1:0]  r_state;
  logic [3:0]  r_rm;
  logic [3:0]  r_rs;
  logic        r_rsh;
  logic [31:0] r_pc;

  logic        r_out_valid;
  logic [2:0]  r_sh_op;
  logic [31:0] r_sh_in;
  logic        r_sh_cin;
  logic [4:0]  r_sh_imm;
  logic [7:0]  r_sh_reg;
  logic [3:0]  r_rf_addr;

  // ---------------------------------------------------------------------------
  // Decode of the offered instruction
  // ---------------------------------------------------------------------------
  logic        w_accept;
  logic [3:0]  w_rot;
  logic [2:0]  w_dec_op;
  logic [4:0]  w_dec_imm;
  logic [31:0] w_dec_in;
  logic [1:0]  w_dec_next;
  logic [3:0]  w_dec_addr;

  assign w_rot = in_instr[F_ROT_HI:F_ROT_LO];

  always_comb begin
    w_dec_op   = SHOP_PASS;
    w_dec_imm  = 5'd0;
    w_dec_in   = imm8_zext(in_instr);
    w_dec_next = ST_OUT;
    w_dec_addr = r_rf_addr;
    if (in_instr[F_I]) begin
      // A zero rotation must be encoded as LSL #0, not ROR #0: the shifter
      // reads ROR #0 as RRX, and a plain immediate leaves the carry untouched.
      if (w_rot != 4'd0) begin
        w_dec_op  = SHOP_ROR_IMM;
        w_dec_imm = {w_rot, 1'b0};
      end
    end else begin
      w_dec_op   = {in_instr[F_TYPE_HI:F_TYPE_LO], in_instr[F_RSH]};
      w_dec_imm  = in_instr[F_RSH] ? 5'd0 : in_instr[F_SHAMT_HI:F_SHAMT_LO];
      w_dec_next = ST_RD_RM;
      // Presenting Rm's address at acceptance lets RD_RM read in its own cycle.
      w_dec_addr = in_instr[F_RM_HI:F_RM_LO];
    end
  end

  // Bits outside the shifter_operand/I fields do not affect this stage.
  logic w_unused_bits;
  assign w_unused_bits = ^{in_instr[31:26], in_instr[24:12]};

  // ---------------------------------------------------------------------------
  // Register read values with PC substitution (PC arithmetic wraps mod 2^32)
  // ---------------------------------------------------------------------------
  logic [31:0] w_pc_off;
  logic [31:0] w_pc_reg;
  logic [31:0] w_rm_val;
  logic [7:0]  w_rs_val;

  assign w_pc_off = r_rsh ? PC_AHEAD_REG : PC_AHEAD_IMM;
  assign w_pc_reg = r_pc + PC_AHEAD_REG;
  assign w_rm_val = (r_rm == REG_PC) ? (r_pc + w_pc_off) : rf_rdata;
  assign w_rs_val = (r_rs == REG_PC) ? w_pc_reg[7:0] : rf_rdata[7:0];

  // ---------------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------------
  assign in_ready = !flush && ((r_state == ST_IDLE) || ((r_state == ST_OUT) && out_ready));
  assign w_accept = in_valid && in_ready;

  // ---------------------------------------------------------------------------
  // FSM and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_rm        <= 4'd0;
      r_rs        <= 4'd0;
      r_rsh       <= 1'b0;
      r_pc        <= 32'd0;
      r_out_valid <= 1'b0;
      r_sh_op     <= 3'd0;
      r_sh_in     <= 32'd0;
      r_sh_cin    <= 1'b0;
      r_sh_imm    <= 5'd0;
      r_sh_reg    <= 8'd0;
      r_rf_addr   <= 4'd0;
    end else if (flush) begin
      // Kill only the control path; data registers keep their values and are
      // meaningless until the next acceptance raises out_valid again.
      r_state     <= ST_IDLE;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_OUT: begin
          if (w_accept) begin
            r_rm        <= in_instr[F_RM_HI:F_RM_LO];
            r_rs        <= in_instr[F_RS_HI:F_RS_LO];
            r_rsh       <= !in_instr[F_I] && in_instr[F_RSH];
            r_pc        <= in_pc;
            r_sh_op     <= w_dec_op;
            r_sh_imm    <= w_dec_imm;
            r_sh_in     <= w_dec_in;
            r_sh_cin    <= in_cflag;
            r_rf_addr   <= w_dec_addr;
            r_state     <= w_dec_next;
            r_out_valid <= (w_dec_next == ST_OUT);
          end else if ((r_state == ST_OUT) && out_ready) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
          end
        end
        ST_RD_RM: begin
          r_sh_in <= w_rm_val;
          if (r_rsh) begin
            r_rf_addr <= r_rs;
            r_state   <= ST_RD_RS;
          end else begin
            r_state     <= ST_OUT;
            r_out_valid <= 1'b1;
          end
        end
        ST_RD_RS: begin
          r_sh_reg    <= w_rs_val;
          r_state     <= ST_OUT;
          r_out_valid <= 1'b1;
        end
        default: begin
          r_state     <= ST_IDLE;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid = r_out_valid;
  assign sh_op     = r_sh_op;
  assign sh_in     = r_sh_in;
  assign sh_cin    = r_sh_cin;
  assign sh_imm    = r_sh_imm;
  assign sh_reg    = r_sh_reg;
  assign rf_addr   = r_rf_addr;

endmodule

// File: tb/tb_shifter_operand_fetch.sv
// Randomised and directed checks of shifter_operand_fetch against an operand model.
// Latency: n/a.
// Backpressure: exercises out_ready stalls, back-to-back acceptance, flush and async reset.
module tb_shifter_operand_fetch;
  import shifter_operand_fetch_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        in_cflag;
  logic [3:0]  rf_addr;
  logic [31:0] rf_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  sh_op;
  logic [31:0] sh_in;
  logic        sh_cin;
  logic [4:0]  sh_imm;
  logic [7:0]  sh_reg;

  shifter_operand_fetch dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_instr (in_instr),
    .in_pc    (in_pc),
    .in_cflag (in_cflag),
    .rf_addr  (rf_addr),
    .rf_rdata (rf_rdata),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sh_op    (sh_op),
    .sh_in    (sh_in),
    .sh_cin   (sh_cin),
    .sh_imm   (sh_imm),
    .sh_reg   (sh_reg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file model with combinational read.
  logic [31:0] rf [16];
  assign rf_rdata = rf[rf_addr];

  int n_vec;
  int n_err;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=0x%08h expected=0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected result of one instruction.
  typedef struct packed {
    logic [3:0]  lat;
    logic [2:0]  op;
    logic [31:0] val;
    logic        cin;
    logic [4:0]  imm;
    logic [7:0]  rg;
    logic [3:0]  a0;
    logic [3:0]  a1;
  } exp_t;

  function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pc, input logic cf);
    exp_t        e;
    int          rm;
    int          rs;
    int          rot;
    bit          reg_sh;
    logic [31:0] rsv;
    e      = '0;
    rm     = int'(ins[3:0]);
    rs     = int'(ins[11:8]);
    rot    = int'(ins[11:8]);
    reg_sh = !ins[25] && ins[4];
    e.cin  = cf;
    if (ins[25]) begin
      e.lat = 4'd1;
      e.val = 32'(ins[7:0]);
      if (rot != 0) begin
        e.op  = {SHT_ROR, 1'b0};
        e.imm = 5'(rot * 2);
      end else begin
        e.op  = 3'b000;
        e.imm = 5'd0;
      end
    end else begin
      e.op  = {ins[6:5], ins[4]};
      e.imm = ins[4] ? 5'd0 : ins[11:7];
      e.lat = reg_sh ? 4'd3 : 4'd2;
      e.a0  = 4'(rm);
      e.a1  = 4'(rs);
      e.val = (rm == 15) ? pc + (reg_sh ? 32'd12 : 32'd8) : rf[rm];
      if (reg_sh) begin
        rsv  = (rs == 15) ? pc + 32'd12 : rf[rs];
        e.rg = rsv[7:0];
      end
    end
    return e;
  endfunction

  task automatic check_outputs(input string tag, input exp_t e);
    chk({tag, ".sh_op"},  32'(sh_op),  32'(e.op));
    chk({tag, ".sh_in"},  sh_in,       e.val);
    chk({tag, ".sh_cin"}, 32'(sh_cin), 32'(e.cin));
    chk({tag, ".sh_imm"}, 32'(sh_imm), 32'(e.imm));
    if (e.lat == 4'd3) chk({tag, ".sh_reg"}, 32'(sh_reg), 32'(e.rg));
  endtask

  // Offer one instruction from IDLE, check read addresses, latency, operands,
  // stability across a stall, and retirement back to IDLE.
  task automatic send(input logic [31:0] ins, input logic [31:0] pc, input logic cf, input int stall);
    exp_t e;
    int   n;
    e = model(ins, pc, cf);
    in_valid  = 1'b1;
    in_instr  = ins;
    in_pc     = pc;
    in_cflag  = cf;
    out_ready = 1'b0;
    #1 chk("in_ready_idle", 32'(in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    // Scramble the inputs so anything not latched shows up as a miscompare.
    in_valid = 1'b0;
    in_instr = $urandom;
    in_pc    = $urandom;
    in_cflag = 1'($urandom);
    #1;
    n = 1;
    while (!out_valid && n < 8) begin
      if (n == 1) chk("rf_addr_rm", 32'(rf_addr), 32'(e.a0));
      if (n == 2) chk("rf_addr_rs", 32'(rf_addr), 32'(e.a1));
      @(negedge clk);
      #1;
      n++;
    end
    chk("latency", 32'(n), 32'(e.lat));
    check_outputs("out", e);
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      #1;
      chk("stall.out_valid", 32'(out_valid), 32'd1);
      chk("stall.in_ready", 32'(in_ready), 32'd0);
      check_outputs("stall", e);
    end
    out_ready = 1'b1;
    #1 chk("in_ready_out", 32'(in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    #1 chk("retire.out_valid", 32'(out_valid), 32'd0);
  endtask

  logic [31:0] ins;
  exp_t        eb;

  initial begin
    n_vec     = 0;
    n_err     = 0;
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_instr  = 32'd0;
    in_pc     = 32'd0;
    in_cflag  = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < 16; i++) rf[i] = $urandom;

    // Reset state.
    #2;
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.sh_op",     32'(sh_op),     32'd0);
    chk("rst.sh_in",     sh_in,          32'd0);
    chk("rst.sh_cin",    32'(sh_cin),    32'd0);
    chk("rst.sh_imm",    32'(sh_imm),    32'd0);
    chk("rst.sh_reg",    32'(sh_reg),    32'd0);
    chk("rst.rf_addr",   32'(rf_addr),   32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("post_rst.in_ready", 32'(in_ready), 32'd1);

    // Directed vectors.
    send(32'hE3A004FF, 32'h0000_0100, 1'b1, 0);
    send(32'hE3A000FF, 32'h0000_0100, 1'b0, 0);
    rf[1] = 32'h1234_5678;
    send(32'hE1A00181, 32'h0000_0200, 1'b1, 0);
    rf[1] = 32'h8000_0000;
    rf[2] = 32'h0000_0104;
    send(32'hE1A00231, 32'h0000_0300, 1'b0, 0);
    send(32'hE1A0000F, 32'h0000_0100, 1'b0, 0);
    send(32'hE1A00F1F, 32'h0000_0100, 1'b1, 3);
    send(32'hE1A00F1F, 32'hFFFF_FFF8, 1'b1, 0);  // PC offset wraps

    // Back-to-back immediates: no bubble.
    in_valid  = 1'b1;
    in_instr  = 32'hE3A00A3C;
    in_pc     = 32'h0000_0400;
    in_cflag  = 1'b1;
    out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    eb        = model(32'hE3A00C81, 32'h0000_0404, 1'b0);
    in_instr  = 32'hE3A00C81;
    in_pc     = 32'h0000_0404;
    in_cflag  = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("b2b.first_valid", 32'(out_valid), 32'd1);
    chk("b2b.first_imm",   32'(sh_imm),    32'd20);
    chk("b2b.in_ready",    32'(in_ready),  32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("b2b.second_valid", 32'(out_valid), 32'd1);
    check_outputs("b2b", eb);
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    #1 chk("b2b.retire", 32'(out_valid), 32'd0);

    // Flush during RD_RS.
    in_valid = 1'b1;
    in_instr = 32'hE1A00231;
    in_pc    = 32'h0000_0500;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_instr = 32'hE3A000FF;
    #1 chk("flush.in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    @(negedge clk);
    flush    = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("flush.out_valid", 32'(out_valid), 32'd0);
    chk("flush.idle", 32'(in_ready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1 chk("flush.quiet", 32'(out_valid), 32'd0);
    end
    send(32'hE1A00181, 32'h0000_0600, 1'b1, 1);

    // Asynchronous reset during RD_RM.
    rf[5]    = 32'hCAFE_F00D;
    in_valid = 1'b1;
    in_instr = 32'hE1A002A5;
    in_pc    = 32'h0000_0700;
    in_cflag = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    #1 chk("arst.rd_rm_addr", 32'(rf_addr), 32'd5);
    rst_n = 1'b0;
    #1;
    chk("arst.out_valid", 32'(out_valid), 32'd0);
    chk("arst.sh_op",     32'(sh_op),     32'd0);
    chk("arst.sh_in",     sh_in,          32'd0);
    chk("arst.sh_cin",    32'(sh_cin),    32'd0);
    chk("arst.sh_imm",    32'(sh_imm),    32'd0);
    chk("arst.sh_reg",    32'(sh_reg),    32'd0);
    chk("arst.rf_addr",   32'(rf_addr),   32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1 chk("arst.quiet", 32'(out_valid), 32'd0);
    end

    // Randomised instructions.
    for (int t = 0; t < 150; t++) begin
      int form;
      for (int i = 0; i < 16; i++) rf[i] = $urandom;
      form = int'($urandom_range(0, 2));
      ins  = $urandom;
      ins[27:26] = 2'b00;
      ins[25]    = (form == 0);
      if (form != 0) begin
        ins[4] = (form == 2);
        if (form == 2) ins[7] = 1'b0;
        if ($urandom_range(0, 3) == 0) ins[3:0] = 4'hF;
        if (form == 2 && $urandom_range(0, 3) == 0) ins[11:8] = 4'hF;
      end else if ($urandom_range(0, 3) == 0) begin
        ins[11:8] = 4'h0;
      end
      send(ins, $urandom, 1'($urandom), int'($urandom_range(0, 2)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/shifter_operand_fetch.md
Name: shifter_operand_fetch

Overview:
- Upstream stage of the barrel shifter in the execute path.
- Accepts one data-processing instruction per handshake and decodes its shifter_operand field.
- Reads Rm and, for register-specified shifts, Rs from the register file through a single shared read port over successive cycles.
- Presents registered, stable operands (op, in, cin, sh_imm, sh_reg) to the shifter under a valid/ready handshake.

Parameters:
PC_AHEAD_IMM, 8, value added to in_pc when Rm==15 and the shift is immediate or there is no shift
PC_AHEAD_REG, 12, value added to in_pc when Rm==15 or Rs==15 and the shift is register-specified

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
flush  input  1  synchronous kill of any in-flight operation
in_valid  input  1  instruction offered
in_ready  output  1  instruction accepted when in_valid&in_ready at clk rise
in_instr  input  32  ARM data-processing instruction word
in_pc  input  32  address of in_instr
in_cflag  input  1  CPSR C flag, sampled on acceptance
rf_addr  output  4  register file read address
rf_rdata  input  32  register file read data, combinational (same cycle as rf_addr)
out_valid  output  1  shifter operands valid
out_ready  input  1  downstream consumes when out_valid&out_ready
sh_op  output  3  shifter op: {shift_type[1:0], reg_shift}
sh_in  output  32  value to be shifted
sh_cin  output  1  carry in
sh_imm  output  5  immediate shift/rotate amount
sh_reg  output  8  Rs[7:0]

Behaviour:
- Reset (rst_n low, async): state=IDLE; out_valid=0; sh_op, sh_in, sh_cin, sh_imm, sh_reg and rf_addr all 0.
- After release: in_ready=1 (IDLE).
- in_ready = !flush && (state==IDLE || (state==OUT && out_ready)).
- Acceptance latches instr, pc and cflag internally.
- Decode uses I=instr[25]:
  - I=1, immediate form:
    - If rot=instr[11:8] != 0: sh_op=3'b110, sh_imm=2*rot, sh_in={24'b0, instr[7:0]}.
    - If rot==0: sh_op=3'b000, sh_imm=0, sh_in={24'b0, instr[7:0]}. The carry then passes through unchanged; ROR #0 would mean RRX, so it must not be used here.
    - Next state OUT. Latency 1 cycle.
  - I=0, instr[4]=0, immediate shift:
    - sh_op={instr[6:5], 1'b0}, sh_imm=instr[11:7].
    - Next state RD_RM. Latency 2 cycles.
  - I=0, instr[4]=1, register shift:
    - sh_op={instr[6:5], 1'b1}, sh_imm=0.
    - Next state RD_RM, then RD_RS. Latency 3 cycles.
    - instr[7]=1 is not a data-processing encoding; upstream never sends it, and behaviour is don't-care apart from reaching OUT.
- RD_RM: rf_addr=instr[3:0]. Capture sh_in=rf_rdata at cycle end. If Rm==15, substitute in_pc+PC_AHEAD_IMM (immediate shift) or in_pc+PC_AHEAD_REG (register shift).
- RD_RS: rf_addr=instr[11:8]. Capture sh_reg=rf_rdata[7:0]. If Rs==15, substitute (in_pc+PC_AHEAD_REG)[7:0].
- In IDLE and OUT, rf_addr holds its last value; the register file must tolerate this.
- sh_cin=latched cflag, registered alongside the other outputs.
- OUT: out_valid=1. All sh_* outputs stay stable until out_ready.
  - out_ready with in_valid: accept back-to-back, with no bubble for immediate forms.
  - out_ready without in_valid: return to IDLE and set out_valid=0 next cycle.
- flush has priority over every transition:
  - Next state IDLE, out_valid=0 next cycle, in_ready=0 in the flush cycle, and no acceptance.
  - Data outputs hold their values; they are don't-care while out_valid=0.
- Asserting rst_n mid-operation abandons the operation immediately; the first post-reset output comes only from a new acceptance.
- All PC arithmetic is modulo 2^32.

Decomposition:
- Shared package (used with the shifter): shift type constants LSL=2'b00, LSR=2'b01, ASR=2'b10, ROR=2'b11; sh_op encodings; FSM state enum IDLE/RD_RM/RD_RS/OUT; instruction field positions (I=25, ROT=11:8, IMM8=7:0, SHAMT=11:7, TYPE=6:5, RSH=4, RS=11:8, RM=3:0).
- No sub-module. Decode is a combinational block inside.

Test Plan:
- 0xE3A004FF accepted with cflag=1, out_ready=1 -> 1 cycle later out_valid=1, sh_op=110, sh_imm=8, sh_in=0x000000FF, sh_cin=1.
- 0xE3A000FF -> sh_op=000, sh_imm=0, sh_in=0x000000FF, after 1 cycle.
- 0xE1A00181 with r1=0x12345678 -> rf_addr=1 in cycle 1; out_valid in cycle 2 with sh_op=000, sh_imm=3, sh_in=0x12345678.
- 0xE1A00231 with r1=0x80000000, r2=0x00000104 -> rf_addr 1 then 2; out_valid in cycle 3 with sh_op=011, sh_in=0x80000000, sh_reg=0x04.
- 0xE1A0000F with in_pc=0x100 -> sh_in=0x108. Same instruction with bit4=1, Rs=15 (0xE1A00F1F) -> sh_in=0x10C, sh_reg=0x0C.
- out_ready=0 held 3 cycles in OUT -> outputs stable and in_ready=0. flush in RD_RS -> out_valid=0 next cycle and IDLE. rst_n low during RD_RM -> all outputs 0 immediately.
